fp_norm_round_unit: RTL and testbench

- Registered post-processing stage for the floating-point adder datapath.
- Classifies two IEEE-style operands (zero/inf/qNaN/sNaN).
- Locates the leading one of a raw positive summed mantissa, normalizes it, applies rounding, and detects overflow/underflow.
- Produces the packed exponent/mantissa of the result one cycle later.

---
 rtl/fp_norm_pkg.sv | 64 ++++++
 rtl/fp_norm_round_unit_if.sv | 55 +++++
 rtl/fp_norm_round_unit_leading_one_detector.sv | 23 ++
 rtl/fp_norm_round_unit.sv | 175 +++++++++++++++++
 tb/tb_fp_norm_round_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_norm_pkg.sv
// Shared types, width constants and helper functions for the FP
// normalize/round post-processing stage.
package fp_norm_pkg;

  // Default operating format is IEEE single precision with three
  // guard/round/sticky bits below the mantissa LSB.
  localparam int DEFAULT_EW = 8;
  localparam int DEFAULT_MW = 23;
  localparam int DEFAULT_RB = 3;

  // Derived widths for the default format.
  localparam int FLOAT_W = DEFAULT_EW + DEFAULT_MW + 1;
  localparam int SUM_W   = DEFAULT_MW + DEFAULT_RB + 2;
  localparam int EXP_T_W = DEFAULT_EW + 2;

  // Format-independent width offsets: one sign bit per operand, a hidden
  // bit plus a carry bit on the summed mantissa, and two extra bits on the
  // working exponent so it can go negative or past all-ones.
  localparam int SIGN_BITS        = FLOAT_W - DEFAULT_EW - DEFAULT_MW;
  localparam int SUM_EXTRA_BITS   = SUM_W - DEFAULT_MW - DEFAULT_RB;
  localparam int EXP_GUARD_BITS   = EXP_T_W - DEFAULT_EW;

  typedef struct packed {
    logic zero;
    logic inf;
    logic qnan;
    logic snan;
  } class_flags_t;

  // Classify an operand from pre-reduced field properties so the function
  // stays independent of the exponent/mantissa widths. E4M3 has no
  // infinities and a single NaN encoding (all ones).
  function automatic class_flags_t classify(
    input logic exp_zero,
    input logic exp_ones,
    input logic mant_zero,
    input logic mant_msb,
    input logic mant_ones,
    input logic is_e4m3
  );
    class_flags_t flags;
    flags = '0;
    flags.zero = exp_zero & mant_zero;
    if (is_e4m3) begin
      flags.qnan = exp_ones & mant_ones;
    end else begin
      flags.inf  = exp_ones & mant_zero;
      flags.qnan = exp_ones & mant_msb;
      flags.snan = exp_ones & ~mant_msb & ~mant_zero;
    end
    return flags;
  endfunction

  // Round-to-nearest-even increment decision: round up above the halfway
  // point, and at exactly halfway only when the kept LSB is odd.
  function automatic logic round_nearest_even(
    input logic guard,
    input logic sticky,
    input logic lsb
  );
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/fp_norm_round_unit_if.sv
// Bundles the transaction inputs and registered results of the
// normalize/round stage. The datapath drives through master, the stage
// itself sits on slave.
interface fp_norm_round_unit_if
  import fp_norm_pkg::*;
#(
  parameter int EXPONENT_WIDTH = DEFAULT_EW,
  parameter int MANTISSA_WIDTH = DEFAULT_MW,
  parameter int ROUNDING_BITS  = DEFAULT_RB
);

  localparam int EW = EXPONENT_WIDTH;
  localparam int MW = MANTISSA_WIDTH;
  localparam int RB = ROUNDING_BITS;

  logic                          in_valid;
  logic [EW+MW+SIGN_BITS-1:0]    a;
  logic [EW+MW+SIGN_BITS-1:0]    b;
  logic [MW+RB+SUM_EXTRA_BITS-1:0] sum_mantissa;
  logic [EW-1:0]                 base_exponent;

  logic                          out_valid;
  logic                          a_is_zero;
  logic                          a_is_inf;
  logic                          a_is_qnan;
  logic                          a_is_snan;
  logic                          b_is_zero;
  logic                          b_is_inf;
  logic                          b_is_qnan;
  logic                          b_is_snan;
  logic [EW-1:0]                 res_exponent;
  logic [MW-1:0]                 res_mantissa;
  logic                          overflow_flag;
  logic                          underflow_flag;
  logic                          zero_flag;

  modport master (
    output in_valid, a, b, sum_mantissa, base_exponent,
    input  out_valid,
    input  a_is_zero, a_is_inf, a_is_qnan, a_is_snan,
    input  b_is_zero, b_is_inf, b_is_qnan, b_is_snan,
    input  res_exponent, res_mantissa,
    input  overflow_flag, underflow_flag, zero_flag
  );

  modport slave (
    input  in_valid, a, b, sum_mantissa, base_exponent,
    output out_valid,
    output a_is_zero, a_is_inf, a_is_qnan, a_is_snan,
    output b_is_zero, b_is_inf, b_is_qnan, b_is_snan,
    output res_exponent, res_mantissa,
    output overflow_flag, underflow_flag, zero_flag
  );

endinterface

// File: rtl/fp_norm_round_unit_leading_one_detector.sv
// Priority encoder returning the index of the most significant set bit.
module leading_one_detector #(
  parameter  int WIDTH = 28,
  localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] value,
  output logic [POS_W-1:0] position,
  output logic             has_leading_one
);

  // Ascending scan so the highest set bit is the last one to win.
  always_comb begin
    position        = '0;
    has_leading_one = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        position        = POS_W'(i);
        has_leading_one = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_norm_round_unit.sv
// Registered post-adder stage: classifies both operands, normalizes the
// raw summed mantissa around its leading one, rounds, and flags
// zero/underflow/overflow. Results appear one cycle after in_valid.
module fp_norm_round_unit
  import fp_norm_pkg::*;
#(
  parameter int EXPONENT_WIDTH   = DEFAULT_EW,
  parameter int MANTISSA_WIDTH   = DEFAULT_MW,
  parameter int ROUND_TO_NEAREST = 1,
  parameter int ROUNDING_BITS    = DEFAULT_RB
) (
  input logic                clk,
  input logic                rst,
  fp_norm_round_unit_if.slave bus
);

  localparam int EW      = EXPONENT_WIDTH;
  localparam int MW      = MANTISSA_WIDTH;
  localparam int RB      = ROUNDING_BITS;
  localparam int K       = MW + RB;
  localparam int SUM_WL  = MW + RB + SUM_EXTRA_BITS;
  localparam int EXP_TWL = EW + EXP_GUARD_BITS;
  localparam int POS_W   = (SUM_WL > 1) ? $clog2(SUM_WL) : 1;

  localparam logic                      IS_E4M3    = (EW == 4) && (MW == 3);
  localparam logic [EW-1:0]             EXP_ONES   = {EW{1'b1}};
  localparam logic signed [EXP_TWL-1:0] EXP_ONES_T = EXP_TWL'((1 << EW) - 1);

  // Operand fields; the sign bit never influences classification.
  logic [EW-1:0] a_exp;
  logic [MW-1:0] a_man;
  logic [EW-1:0] b_exp;
  logic [MW-1:0] b_man;
  logic [1:0]    unused_sign_bits;

  assign a_exp            = bus.a[EW+MW-1:MW];
  assign a_man            = bus.a[MW-1:0];
  assign b_exp            = bus.b[EW+MW-1:MW];
  assign b_man            = bus.b[MW-1:0];
  assign unused_sign_bits = {bus.a[EW+MW], bus.b[EW+MW]};

  class_flags_t a_class;
  class_flags_t b_class;

  assign a_class = classify(a_exp == '0, &a_exp, a_man == '0, a_man[MW-1], &a_man, IS_E4M3);
  assign b_class = classify(b_exp == '0, &b_exp, b_man == '0, b_man[MW-1], &b_man, IS_E4M3);

  logic [POS_W-1:0] lead_pos;
  logic             has_one;

  leading_one_detector #(
    .WIDTH (SUM_WL)
  ) u_lod (
    .value           (bus.sum_mantissa),
    .position        (lead_pos),
    .has_leading_one (has_one)
  );

  logic [SUM_WL-1:0]         norm;
  logic [POS_W-1:0]          shift_left;
  logic signed [EXP_TWL-1:0] exp_t;

  // Put the leading one at the hidden-bit position K. A carry out shifts
  // right by one and keeps the lost bit alive as sticky; otherwise shift
  // left to close the gap. The exponent tracks the move in signed width.
  always_comb begin
    shift_left = POS_W'(K) - lead_pos;
    if (lead_pos == POS_W'(K + 1)) begin
      norm    = bus.sum_mantissa >> 1;
      norm[0] = norm[0] | bus.sum_mantissa[0];
    end else begin
      norm = bus.sum_mantissa << shift_left;
    end
    exp_t = {{EXP_GUARD_BITS{1'b0}}, bus.base_exponent} + EXP_TWL'(lead_pos) - EXP_TWL'(K);
  end

  logic [MW-1:0]                 mant_pre;
  logic [RB-1:0]                 rbits;
  logic                          guard_bit;
  logic                          sticky_bit;
  logic [SUM_WL-K-1:0]           unused_norm_top;

  assign mant_pre        = norm[K-1:RB];
  assign rbits           = norm[RB-1:0];
  assign guard_bit       = rbits[RB-1];
  assign sticky_bit      = |rbits[RB-2:0];
  assign unused_norm_top = norm[SUM_WL-1:K];

  logic          round_up;
  logic [MW:0]   mant_inc;
  logic [EW-1:0] exp_inc;
  logic [EW-1:0] next_exponent;
  logic [MW-1:0] next_mantissa;
  logic          next_overflow;
  logic          next_underflow;
  logic          next_zero;

  // Choose the result in priority order: zero sum, underflow flush,
  // overflow saturate to inf, otherwise round; a rounding carry bumps the
  // exponent and may itself overflow into inf.
  always_comb begin
    round_up       = 1'b0;
    mant_inc       = '0;
    exp_inc        = '0;
    next_exponent  = '0;
    next_mantissa  = '0;
    next_overflow  = 1'b0;
    next_underflow = 1'b0;
    next_zero      = 1'b0;
    if (!has_one) begin
      next_zero = 1'b1;
    end else if (exp_t <= 0) begin
      next_underflow = 1'b1;
    end else if (exp_t >= EXP_ONES_T) begin
      next_overflow = 1'b1;
      next_exponent = EXP_ONES;
    end else begin
      if (ROUND_TO_NEAREST != 0) begin
        round_up = round_nearest_even(guard_bit, sticky_bit, mant_pre[0]);
      end
      mant_inc = {1'b0, mant_pre} + {{MW{1'b0}}, round_up};
      if (mant_inc[MW]) begin
        exp_inc       = exp_t[EW-1:0] + EW'(1);
        next_mantissa = '0;
        if (exp_inc == EXP_ONES) begin
          next_overflow = 1'b1;
        end
        next_exponent = exp_inc;
      end else begin
        next_exponent = exp_t[EW-1:0];
        next_mantissa = mant_inc[MW-1:0];
      end
    end
  end

  // Output registers: cleared by reset (which also drops any coincident
  // transaction), loaded on in_valid, held otherwise; out_valid simply
  // follows in_valid by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.a_is_zero      <= 1'b0;
      bus.a_is_inf       <= 1'b0;
      bus.a_is_qnan      <= 1'b0;
      bus.a_is_snan      <= 1'b0;
      bus.b_is_zero      <= 1'b0;
      bus.b_is_inf       <= 1'b0;
      bus.b_is_qnan      <= 1'b0;
      bus.b_is_snan      <= 1'b0;
      bus.res_exponent   <= '0;
      bus.res_mantissa   <= '0;
      bus.overflow_flag  <= 1'b0;
      bus.underflow_flag <= 1'b0;
      bus.zero_flag      <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.a_is_zero      <= a_class.zero;
        bus.a_is_inf       <= a_class.inf;
        bus.a_is_qnan      <= a_class.qnan;
        bus.a_is_snan      <= a_class.snan;
        bus.b_is_zero      <= b_class.zero;
        bus.b_is_inf       <= b_class.inf;
        bus.b_is_qnan      <= b_class.qnan;
        bus.b_is_snan      <= b_class.snan;
        bus.res_exponent   <= next_exponent;
        bus.res_mantissa   <= next_mantissa;
        bus.overflow_flag  <= next_overflow;
        bus.underflow_flag <= next_underflow;
        bus.zero_flag      <= next_zero;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round_unit.sv
// Self-checking bench for fp_norm_round_unit: FP32 round-to-nearest,
// FP32 truncate and E4M3 instances checked against a value-level model.
module tb_fp_norm_round_unit;
  import fp_norm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fp_norm_round_unit_if #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUNDING_BITS(3)) rne_if ();
  fp_norm_round_unit_if #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUNDING_BITS(3)) trunc_if ();
  fp_norm_round_unit_if #(.EXPONENT_WIDTH(4), .MANTISSA_WIDTH(3),  .ROUNDING_BITS(3)) e4_if ();

  fp_norm_round_unit #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(1), .ROUNDING_BITS(3))
    dut_rne (.clk(clk), .rst(rst), .bus(rne_if.slave));
  fp_norm_round_unit #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(0), .ROUNDING_BITS(3))
    dut_trunc (.clk(clk), .rst(rst), .bus(trunc_if.slave));
  fp_norm_round_unit #(.EXPONENT_WIDTH(4), .MANTISSA_WIDTH(3), .ROUND_TO_NEAREST(1), .ROUNDING_BITS(3))
    dut_e4 (.clk(clk), .rst(rst), .bus(e4_if.slave));

  logic [34:0] rne_word, trunc_word;
  logic [7:0]  rne_class, e4_class;
  logic [10:0] e4_word;

  assign rne_word   = {rne_if.out_valid, rne_if.res_exponent, rne_if.res_mantissa,
                       rne_if.overflow_flag, rne_if.underflow_flag, rne_if.zero_flag};
  assign trunc_word = {trunc_if.out_valid, trunc_if.res_exponent, trunc_if.res_mantissa,
                       trunc_if.overflow_flag, trunc_if.underflow_flag, trunc_if.zero_flag};
  assign rne_class  = {rne_if.a_is_zero, rne_if.a_is_inf, rne_if.a_is_qnan, rne_if.a_is_snan,
                       rne_if.b_is_zero, rne_if.b_is_inf, rne_if.b_is_qnan, rne_if.b_is_snan};
  assign e4_word    = {e4_if.out_valid, e4_if.res_exponent, e4_if.res_mantissa,
                       e4_if.overflow_flag, e4_if.underflow_flag, e4_if.zero_flag};
  assign e4_class   = {e4_if.a_is_zero, e4_if.a_is_inf, e4_if.a_is_qnan, e4_if.a_is_snan,
                       e4_if.b_is_zero, e4_if.b_is_inf, e4_if.b_is_qnan, e4_if.b_is_snan};

  // Value-level model: find the magnitude of the sum, scale it so the
  // leading one is the hidden bit, and round the exact remainder.
  function automatic void ref_result(input int ew, input int mw, input int rb, input bit rne,
                                     input longint sum, input int base,
                                     output int e, output longint m,
                                     output bit ovf, output bit udf, output bit zf);
    int     k, p, et, all1;
    longint full, sig, rem, half;
    k = mw + rb; all1 = (1 << ew) - 1;
    e = 0; m = 0; ovf = 0; udf = 0; zf = 0;
    if (sum == 0) begin zf = 1; return; end
    p = 0;
    for (int i = 0; i < 62; i++) if (((sum >> i) & 1) != 0) p = i;
    et = base + p - k;
    if (et <= 0) begin udf = 1; return; end
    if (et >= all1) begin ovf = 1; e = all1; return; end
    full = sum << (k + 1 - p);
    sig  = full >> (rb + 1);
    rem  = full & ((longint'(1) << (rb + 1)) - 1);
    half = longint'(1) << rb;
    if (rne && (rem > half || (rem == half && (sig & 1) != 0))) sig = sig + 1;
    if (sig == (longint'(1) << (mw + 1))) begin sig = longint'(1) << mw; et = et + 1; end
    if (et >= all1) begin ovf = 1; e = all1; return; end
    e = et;
    m = sig - (longint'(1) << mw);
  endfunction

  function automatic logic [3:0] ref_class(input int ew, input int mw, input longint v);
    longint ex, mn, all1;
    bit     ones, msb;
    all1 = (longint'(1) << ew) - 1;
    ex   = (v >> mw) & all1;
    mn   = v & ((longint'(1) << mw) - 1);
    ones = (ex == all1);
    msb  = ((mn >> (mw - 1)) & 1) == 1;
    if (ew == 4 && mw == 3) return {ex == 0 && mn == 0, 1'b0, ones && mn == 7, 1'b0};
    return {ex == 0 && mn == 0, ones && mn == 0, ones && msb, ones && !msb && mn != 0};
  endfunction

  function automatic logic [34:0] expect_f32(input bit rne, input logic [SUM_W-1:0] s, input logic [7:0] base);
    int e; longint m; bit ovf, udf, zf;
    logic [7:0] e8; logic [22:0] m23;
    ref_result(8, 23, 3, rne, longint'(s), int'(base), e, m, ovf, udf, zf);
    e8 = e[7:0]; m23 = m[22:0];
    return {1'b1, e8, m23, ovf, udf, zf};
  endfunction

  function automatic logic [10:0] expect_e4(input logic [7:0] s, input logic [3:0] base);
    int e; longint m; bit ovf, udf, zf;
    logic [3:0] e4; logic [2:0] m3;
    ref_result(4, 3, 3, 1'b1, longint'(s), int'(base), e, m, ovf, udf, zf);
    e4 = e[3:0]; m3 = m[2:0];
    return {1'b1, e4, m3, ovf, udf, zf};
  endfunction

  task automatic apply_stimulus_f32(input logic [FLOAT_W-1:0] a_v, input logic [FLOAT_W-1:0] b_v,
                                    input logic [SUM_W-1:0] s_v, input logic [7:0] base_v);
    rne_if.in_valid = 1'b1;   rne_if.a = a_v;   rne_if.b = b_v;
    rne_if.sum_mantissa = s_v;   rne_if.base_exponent = base_v;
    trunc_if.in_valid = 1'b1; trunc_if.a = a_v; trunc_if.b = b_v;
    trunc_if.sum_mantissa = s_v; trunc_if.base_exponent = base_v;
  endtask

  task automatic apply_stimulus_e4(input logic [7:0] a_v, input logic [7:0] b_v,
                                   input logic [7:0] s_v, input logic [3:0] base_v);
    e4_if.in_valid = 1'b1; e4_if.a = a_v; e4_if.b = b_v;
    e4_if.sum_mantissa = s_v; e4_if.base_exponent = base_v;
  endtask

  task automatic idle_all();
    rne_if.in_valid = 1'b0; trunc_if.in_valid = 1'b0; e4_if.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({rne_word, rne_class} !== 43'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_fp32: got %h/%h expected 0", rne_word, rne_class);
    end
    vectors++;
    if ({e4_word, e4_class} !== 19'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_e4m3: got %h/%h expected 0", e4_word, e4_class);
    end
    rst = 1'b0;
  endtask

  logic [34:0] last_rne;

  task automatic test_directed();
    logic [SUM_W-1:0] d_sum  [12];
    logic [7:0]       d_base [12];
    logic [34:0]      d_exp  [12];
    logic [34:0]      t_exp;
    d_sum  = '{28'h4000000, 28'h8000000, 28'h8000000, 28'h7FFFFFC, 28'h4000004, 28'h4000005,
               28'h2000000, 28'h0000000, 28'h8000009, 28'h7FFFFFC, 28'h2000000, 28'h4000000};
    d_base = '{8'd127, 8'd127, 8'd254, 8'd127, 8'd127, 8'd127,
               8'd1,   8'd100, 8'd127, 8'd254, 8'd2,   8'd254};
    d_exp  = '{{1'b1, 8'd127, 23'h0, 3'b000}, {1'b1, 8'd128, 23'h0, 3'b000},
               {1'b1, 8'd255, 23'h0, 3'b100}, {1'b1, 8'd128, 23'h0, 3'b000},
               {1'b1, 8'd127, 23'h0, 3'b000}, {1'b1, 8'd127, 23'h1, 3'b000},
               {1'b1, 8'd0,   23'h0, 3'b010}, {1'b1, 8'd0,   23'h0, 3'b001},
               {1'b1, 8'd128, 23'h1, 3'b000}, {1'b1, 8'd255, 23'h0, 3'b100},
               {1'b1, 8'd1,   23'h0, 3'b000}, {1'b1, 8'd254, 23'h0, 3'b000}};
    for (int i = 0; i < 12; i++) begin
      apply_stimulus_f32(32'h3F800000, 32'h3F800000, d_sum[i], d_base[i]);
      t_exp = expect_f32(1'b0, d_sum[i], d_base[i]);
      @(posedge clk);
      #1;
      vectors++;
      if (rne_word !== d_exp[i]) begin
        miscompares++;
        $display("[TB] FAIL directed_rne[%0d]: got %h expected %h", i, rne_word, d_exp[i]);
      end
      vectors++;
      if (trunc_word !== t_exp) begin
        miscompares++;
        $display("[TB] FAIL directed_trunc[%0d]: got %h expected %h", i, trunc_word, t_exp);
      end
      last_rne = d_exp[i];
    end
  endtask

  task automatic test_hold();
    idle_all();
    @(posedge clk);
    #1;
    vectors++;
    if (rne_word !== {1'b0, last_rne[33:0]}) begin
      miscompares++;
      $display("[TB] FAIL hold: got %h expected %h", rne_word, {1'b0, last_rne[33:0]});
    end
  endtask

  task automatic test_classification();
    logic [31:0] c_a [4];
    logic [31:0] c_b [4];
    logic [7:0]  c_exp [4];
    c_a   = '{32'h7FC00000, 32'h7F800001, 32'h3F800000, 32'hFFBFFFFF};
    c_b   = '{32'hFF800000, 32'h80000000, 32'h7FFFFFFF, 32'h00000001};
    c_exp = '{8'b0010_0100, 8'b0001_1000, 8'b0000_0010, 8'b0001_0000};
    for (int i = 0; i < 4; i++) begin
      apply_stimulus_f32(c_a[i], c_b[i], 28'h4000000, 8'd127);
      @(posedge clk);
      #1;
      vectors++;
      if (rne_class !== c_exp[i]) begin
        miscompares++;
        $display("[TB] FAIL class_fp32[%0d]: got %b expected %b", i, rne_class, c_exp[i]);
      end
    end
    idle_all();
  endtask

  task automatic test_e4m3();
    logic [7:0]  e_a [4];
    logic [7:0]  e_b [4];
    logic [7:0]  e_sum [4];
    logic [3:0]  e_base [4];
    logic [7:0]  e_cls [4];
    logic [10:0] e_res [4];
    e_a    = '{8'h7F, 8'hF8, 8'h7E, 8'h38};
    e_b    = '{8'h78, 8'h00, 8'hFF, 8'h80};
    e_sum  = '{8'h40, 8'h80, 8'h7C, 8'h00};
    e_base = '{4'd7,  4'd14, 4'd7,  4'd3};
    e_cls  = '{8'b0010_0000, 8'b0000_1000, 8'b0000_0010, 8'b0000_1000};
    e_res  = '{{1'b1, 4'd7, 3'd0, 3'b000}, {1'b1, 4'd15, 3'd0, 3'b100},
               {1'b1, 4'd8, 3'd0, 3'b000}, {1'b1, 4'd0,  3'd0, 3'b001}};
    for (int i = 0; i < 4; i++) begin
      apply_stimulus_e4(e_a[i], e_b[i], e_sum[i], e_base[i]);
      @(posedge clk);
      #1;
      vectors++;
      if (e4_class !== e_cls[i]) begin
        miscompares++;
        $display("[TB] FAIL class_e4m3[%0d]: got %b expected %b", i, e4_class, e_cls[i]);
      end
      vectors++;
      if (e4_word !== e_res[i]) begin
        miscompares++;
        $display("[TB] FAIL result_e4m3[%0d]: got %h expected %h", i, e4_word, e_res[i]);
      end
    end
    idle_all();
  endtask

  task automatic test_reset_priority();
    apply_stimulus_f32(32'h7FC00000, 32'hFF800000, 28'h4000005, 8'd127);
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply_stimulus_f32(32'h7F800001, 32'h00000000, 28'h8000000, 8'd200);
    @(posedge clk);
    #1;
    vectors++;
    if ({rne_word, rne_class} !== 43'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_priority: got %h/%h expected 0", rne_word, rne_class);
    end
    rst = 1'b0;
    idle_all();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_float32();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 4))
      0: v[30:23] = 8'hFF;
      1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      2: v[30:0] = '0;
      3: v[30:23] = '0;
      default: ;
    endcase
    return v;
  endfunction

  task automatic test_back_to_back();
    logic [34:0] q_rne [$];
    logic [34:0] q_trunc [$];
    logic [7:0]  q_cls [$];
    logic [10:0] q_e4 [$];
    logic [7:0]  q_e4cls [$];
    logic [31:0] fa, fb;
    logic [SUM_W-1:0] fs;
    logic [7:0]  fbase, ea, eb, es;
    logic [3:0]  ebase;
    logic [34:0] x_rne, x_trunc;
    logic [7:0]  x_cls, x_e4cls;
    logic [10:0] x_e4;
    for (int i = 0; i < 400; i++) begin
      fa = rand_float32(); fb = rand_float32();
      fs = SUM_W'($urandom) >> $urandom_range(0, SUM_W - 1);
      if ($urandom_range(0, 15) == 0) fs = '0;
      if ($urandom_range(0, 3) == 0) fs[2:0] = 3'b100;
      fbase = 8'($urandom);
      ea = 8'($urandom); eb = 8'($urandom);
      es = 8'($urandom) >> $urandom_range(0, 7);
      ebase = 4'($urandom);
      apply_stimulus_f32(fa, fb, fs, fbase);
      apply_stimulus_e4(ea, eb, es, ebase);
      q_rne.push_back(expect_f32(1'b1, fs, fbase));
      q_trunc.push_back(expect_f32(1'b0, fs, fbase));
      q_cls.push_back({ref_class(8, 23, longint'(fa)), ref_class(8, 23, longint'(fb))});
      q_e4.push_back(expect_e4(es, ebase));
      q_e4cls.push_back({ref_class(4, 3, longint'(ea)), ref_class(4, 3, longint'(eb))});
      @(posedge clk);
      #1;
      x_rne = q_rne.pop_front(); x_trunc = q_trunc.pop_front(); x_cls = q_cls.pop_front();
      x_e4 = q_e4.pop_front(); x_e4cls = q_e4cls.pop_front();
      vectors++;
      if (rne_word !== x_rne) begin
        miscompares++;
        $display("[TB] FAIL b2b_rne[%0d]: sum=%h base=%0d got %h expected %h", i, fs, fbase, rne_word, x_rne);
      end
      vectors++;
      if (trunc_word !== x_trunc) begin
        miscompares++;
        $display("[TB] FAIL b2b_trunc[%0d]: sum=%h base=%0d got %h expected %h", i, fs, fbase, trunc_word, x_trunc);
      end
      vectors++;
      if (rne_class !== x_cls) begin
        miscompares++;
        $display("[TB] FAIL b2b_class[%0d]: a=%h b=%h got %b expected %b", i, fa, fb, rne_class, x_cls);
      end
      vectors++;
      if (e4_word !== x_e4) begin
        miscompares++;
        $display("[TB] FAIL b2b_e4m3[%0d]: sum=%h base=%0d got %h expected %h", i, es, ebase, e4_word, x_e4);
      end
      vectors++;
      if (e4_class !== x_e4cls) begin
        miscompares++;
        $display("[TB] FAIL b2b_e4class[%0d]: a=%h b=%h got %b expected %b", i, ea, eb, e4_class, x_e4cls);
      end
    end
    idle_all();
  endtask

  initial begin
    rne_if.in_valid = 1'b0; rne_if.a = '0; rne_if.b = '0;
    rne_if.sum_mantissa = '0; rne_if.base_exponent = '0;
    trunc_if.in_valid = 1'b0; trunc_if.a = '0; trunc_if.b = '0;
    trunc_if.sum_mantissa = '0; trunc_if.base_exponent = '0;
    e4_if.in_valid = 1'b0; e4_if.a = '0; e4_if.b = '0;
    e4_if.sum_mantissa = '0; e4_if.base_exponent = '0;
    test_reset();
    test_directed();
    test_hold();
    test_classification();
    test_e4m3();
    test_reset_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
